// File: rtl/fft16_frame_io.sv
// rtl/fft16_frame_io.sv - 16-sample frame packer, FFT handshake and double-buffered spectrum store.
// Optional FFT_IO_MAG_EN: store |re|+|im| per bin instead of the raw result word.
module fft16_frame_io #(
    parameter int TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] S_DATA,
    input  logic        S_VALID,
    output logic        S_READY,
    output logic [31:0] FFT_A,
    output logic        FFT_START,
    input  logic        FFT_DONE,
    input  logic [31:0] FFT_Y,
    input  logic [3:0]  RD_ADDR,
    output logic [31:0] RD_DATA,
    output logic        FRAME_RDY,
    output logic        BUSY,
    output logic        ERR
);

    typedef enum logic [1:0] {ST_FILL, ST_SEND, ST_WAIT, ST_CAPTURE} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state, next_state;
    logic [3:0]  in_idx, out_idx, cap_idx;
    logic [7:0]  wait_cnt;
    logic        bank_sel;
    logic [31:0] rd_q;
    logic        frame_rdy_q;
    logic        err_q;
    logic [15:0] sample_buf [0:15];
    logic [31:0] bank [0:1][0:15];
    logic [31:0] store_word;
    logic        accept;

    assign accept = (state == ST_FILL) && S_VALID;

`ifdef FFT_IO_MAG_EN
    logic [16:0] re_abs, im_abs, mag;
    // Sign-extend to 17 bits before negating so |-32768| is exact.
    always_comb begin
        re_abs = FFT_Y[31] ? 17'd0 - {FFT_Y[31], FFT_Y[31:16]} : {1'b0, FFT_Y[31:16]};
        im_abs = FFT_Y[15] ? 17'd0 - {FFT_Y[15], FFT_Y[15:0]}  : {1'b0, FFT_Y[15:0]};
        mag    = re_abs + im_abs;
        store_word = {15'd0, mag};
    end
`else
    assign store_word = FFT_Y;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) state <= ST_FILL;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_FILL:    if (S_VALID && in_idx == 4'd15) next_state = ST_SEND;
            ST_SEND:    if (out_idx == 4'd15) next_state = ST_WAIT;
            ST_WAIT: begin
                if (FFT_DONE)                   next_state = ST_CAPTURE;
                else if (wait_cnt == WAIT_LAST) next_state = ST_FILL;
            end
            ST_CAPTURE: if (cap_idx == 4'd15) next_state = ST_FILL;
            default:    next_state = ST_FILL;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            in_idx      <= '0;
            out_idx     <= '0;
            cap_idx     <= '0;
            wait_cnt    <= '0;
            bank_sel    <= 1'b0;
            rd_q        <= '0;
            frame_rdy_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            frame_rdy_q <= 1'b0;
            rd_q        <= bank[bank_sel][RD_ADDR];
            if (accept) in_idx <= in_idx + 4'd1;
            if (state == ST_SEND) out_idx <= out_idx + 4'd1;
            if (state == ST_WAIT) begin
                if (FFT_DONE) begin
                    wait_cnt <= '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    wait_cnt <= '0;
                    err_q    <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
            end
            // Bank flips only after the last bin lands, so readers never see a partial frame.
            if (state == ST_CAPTURE) begin
                cap_idx <= cap_idx + 4'd1;
                if (cap_idx == 4'd15) begin
                    bank_sel    <= ~bank_sel;
                    frame_rdy_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < 16; i++)
                    bank[b][i] <= '0;
        end else if (state == ST_CAPTURE) begin
            bank[~bank_sel][cap_idx] <= store_word;
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) sample_buf[in_idx] <= S_DATA;
    end

    assign S_READY   = !RESET && (state == ST_FILL);
    assign FFT_A     = (!RESET && state == ST_SEND) ? {sample_buf[out_idx], 16'h0000} : 32'd0;
    assign FFT_START = !RESET && (state == ST_SEND) && (out_idx == 4'd15);
    assign RD_DATA   = RESET ? 32'd0 : rd_q;
    assign FRAME_RDY = !RESET && frame_rdy_q;
    assign BUSY      = !RESET && (state != ST_FILL);
    assign ERR       = !RESET && err_q;

endmodule

// File: tb/tb_fft16_frame_io.sv
// tb/tb_fft16_frame_io.sv - directed bench for fft16_frame_io (raw or FFT_IO_MAG_EN build).
module tb_fft16_frame_io;

    localparam int TIMEOUT = 64;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [15:0] S_DATA = '0;
    logic        S_VALID = 1'b0;
    logic        S_READY;
    logic [31:0] FFT_A;
    logic        FFT_START;
    logic        FFT_DONE = 1'b0;
    logic [31:0] FFT_Y = '0;
    logic [3:0]  RD_ADDR = '0;
    logic [31:0] RD_DATA;
    logic        FRAME_RDY;
    logic        BUSY;
    logic        ERR;

    int n_cmp = 0;
    int n_bad = 0;

    fft16_frame_io #(.TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RESET(RESET), .S_DATA(S_DATA), .S_VALID(S_VALID), .S_READY(S_READY),
        .FFT_A(FFT_A), .FFT_START(FFT_START), .FFT_DONE(FFT_DONE), .FFT_Y(FFT_Y),
        .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .FRAME_RDY(FRAME_RDY), .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // mode 0: bin k = {k, -k}; mode 1: corner magnitudes at bins 0/1, then {k+3, k}
    function automatic logic [31:0] y_word(input int mode, input int k);
        if (mode == 0) return {16'(k), 16'(-k)};
        if (k == 0) return 32'h8000_8000;
        if (k == 1) return 32'h7FFF_8000;
        return {16'(k + 3), 16'(k)};
    endfunction

    function automatic logic [31:0] exp_word(input int mode, input int k);
`ifdef FFT_IO_MAG_EN
        if (mode == 0) return 32'(2 * k);
        if (k == 0) return 32'h0001_0000;
        if (k == 1) return 32'h0000_FFFF;
        return 32'(2 * k + 3);
`else
        return y_word(mode, k);
`endif
    endfunction

    task automatic fill(input int base);
        S_VALID = 1'b1;
        for (int i = 0; i < 16; i++) begin
            S_DATA = 16'(base + i);
            tick;
        end
        S_VALID = 1'b0;
    endtask

    // Full frame with DONE 10 cycles after START; returns in cycle d+17.
    task automatic run_frame(input int base, input int mode);
        fill(base);
        repeat (16) tick;
        repeat (9) tick;
        FFT_DONE = 1'b1;
        tick;
        FFT_DONE = 1'b0;
        for (int k = 0; k < 16; k++) begin
            FFT_Y = y_word(mode, k);
            tick;
        end
        FFT_Y = '0;
    endtask

    task automatic test_reset;
        tick;
        n_cmp++; if ({S_READY, FFT_A, FFT_START, RD_DATA, FRAME_RDY, BUSY, ERR} !== '0) begin n_bad++; $display("FAIL reset_outputs: got ready=%b a=%h start=%b rd=%h rdy=%b busy=%b err=%b want all 0", S_READY, FFT_A, FFT_START, RD_DATA, FRAME_RDY, BUSY, ERR); end
        RESET = 1'b0;
        #1;
        n_cmp++; if (S_READY !== 1'b1 || BUSY !== 1'b0) begin n_bad++; $display("FAIL reset_release: got ready=%b busy=%b want 1/0", S_READY, BUSY); end
        RD_ADDR = 4'd7;
        tick;
        n_cmp++; if (RD_DATA !== 32'd0) begin n_bad++; $display("FAIL reset_rd: got %h want 0", RD_DATA); end
    endtask

    task automatic test_send;
        for (int i = 0; i < 16; i++) begin
            S_VALID = 1'b1;
            S_DATA  = 16'(i + 1);
            n_cmp++; if (S_READY !== 1'b1) begin n_bad++; $display("FAIL fill_ready[%0d]: got %b want 1", i, S_READY); end
            tick;
        end
        S_DATA = 16'hBEEF;
        for (int k = 0; k < 16; k++) begin
            n_cmp++; if (FFT_A !== {16'(k + 1), 16'h0000}) begin n_bad++; $display("FAIL send_a[%0d]: got %h want %h", k, FFT_A, {16'(k + 1), 16'h0000}); end
            n_cmp++; if (FFT_START !== (k == 15) || S_READY !== 1'b0) begin n_bad++; $display("FAIL send_ctl[%0d]: got start=%b ready=%b want start=%b ready=0", k, FFT_START, S_READY, k == 15); end
            tick;
        end
        S_VALID = 1'b0;
        n_cmp++; if (FFT_A !== 32'd0 || BUSY !== 1'b1 || FFT_START !== 1'b0) begin n_bad++; $display("FAIL wait_entry: got a=%h busy=%b start=%b want 0/1/0", FFT_A, BUSY, FFT_START); end
    endtask

    task automatic test_capture;
        repeat (9) tick;
        FFT_DONE = 1'b1;
        tick;
        FFT_DONE = 1'b0;
        for (int k = 0; k < 16; k++) begin
            FFT_Y = y_word(0, k);
            n_cmp++; if (FRAME_RDY !== 1'b0 || BUSY !== 1'b1) begin n_bad++; $display("FAIL capture_ctl[%0d]: got rdy=%b busy=%b want 0/1", k, FRAME_RDY, BUSY); end
            tick;
        end
        FFT_Y = '0;
        n_cmp++; if (FRAME_RDY !== 1'b1 || S_READY !== 1'b1 || BUSY !== 1'b0) begin n_bad++; $display("FAIL commit: got rdy=%b ready=%b busy=%b want 1/1/0", FRAME_RDY, S_READY, BUSY); end
        tick;
        n_cmp++; if (FRAME_RDY !== 1'b0) begin n_bad++; $display("FAIL commit_pulse: got %b want 0", FRAME_RDY); end
        for (int k = 0; k < 16; k++) begin
            RD_ADDR = 4'(k);
            tick;
            n_cmp++; if (RD_DATA !== exp_word(0, k)) begin n_bad++; $display("FAIL bin0[%0d]: got %h want %h", k, RD_DATA, exp_word(0, k)); end
        end
    endtask

    task automatic test_bank_switch;
        RD_ADDR = 4'd3;
        fill(200);
        repeat (25) tick;
        FFT_DONE = 1'b1;
        tick;
        FFT_DONE = 1'b0;
        for (int k = 0; k < 16; k++) begin
            n_cmp++; if (RD_DATA !== exp_word(0, 3)) begin n_bad++; $display("FAIL hold_old[%0d]: got %h want %h", k, RD_DATA, exp_word(0, 3)); end
            FFT_Y = y_word(1, k);
            tick;
        end
        FFT_Y = '0;
        n_cmp++; if (RD_DATA !== exp_word(0, 3) || FRAME_RDY !== 1'b1) begin n_bad++; $display("FAIL switch_d17: got rd=%h rdy=%b want %h/1", RD_DATA, FRAME_RDY, exp_word(0, 3)); end
        tick;
        n_cmp++; if (RD_DATA !== exp_word(1, 3)) begin n_bad++; $display("FAIL switch_d18: got %h want %h", RD_DATA, exp_word(1, 3)); end
    endtask

    task automatic test_mag_corners;
        for (int k = 0; k < 3; k++) begin
            RD_ADDR = 4'(k);
            tick;
            n_cmp++; if (RD_DATA !== exp_word(1, k)) begin n_bad++; $display("FAIL corner[%0d]: got %h want %h", k, RD_DATA, exp_word(1, k)); end
        end
    endtask

    task automatic test_timeout;
        bit late_bad;
        RD_ADDR = 4'd3;
        fill(300);
        repeat (16) tick;
        for (int i = 0; i < TIMEOUT; i++) begin
            n_cmp++; if (ERR !== 1'b0 || BUSY !== 1'b1 || FRAME_RDY !== 1'b0) begin n_bad++; $display("FAIL wait[%0d]: got err=%b busy=%b rdy=%b want 0/1/0", i, ERR, BUSY, FRAME_RDY); end
            tick;
        end
        n_cmp++; if (ERR !== 1'b1 || BUSY !== 1'b0 || S_READY !== 1'b1 || FRAME_RDY !== 1'b0) begin n_bad++; $display("FAIL timeout: got err=%b busy=%b ready=%b rdy=%b want 1/0/1/0", ERR, BUSY, S_READY, FRAME_RDY); end
        n_cmp++; if (RD_DATA !== exp_word(1, 3)) begin n_bad++; $display("FAIL timeout_rd: got %h want %h", RD_DATA, exp_word(1, 3)); end
        FFT_DONE = 1'b1;
        FFT_Y = 32'h1234_5678;
        tick;
        FFT_DONE = 1'b0;
        late_bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (BUSY !== 1'b0 || FRAME_RDY !== 1'b0 || S_READY !== 1'b1) late_bad = 1'b1;
            tick;
        end
        FFT_Y = '0;
        n_cmp++; if (late_bad) begin n_bad++; $display("FAIL late_done: got busy/rdy activity want idle FILL"); end
        n_cmp++; if (ERR !== 1'b1 || RD_DATA !== exp_word(1, 3)) begin n_bad++; $display("FAIL late_state: got err=%b rd=%h want 1/%h", ERR, RD_DATA, exp_word(1, 3)); end
    endtask

    task automatic check_after_reset(input string tag);
        n_cmp++; if ({S_READY, FFT_A, FFT_START, RD_DATA, FRAME_RDY, BUSY, ERR} !== '0) begin n_bad++; $display("FAIL %s_assert: got ready=%b a=%h start=%b rd=%h rdy=%b busy=%b err=%b want all 0", tag, S_READY, FFT_A, FFT_START, RD_DATA, FRAME_RDY, BUSY, ERR); end
        tick;
        n_cmp++; if ({S_READY, FFT_A, FFT_START, RD_DATA, FRAME_RDY, BUSY, ERR} !== '0) begin n_bad++; $display("FAIL %s_next: got ready=%b a=%h start=%b rd=%h rdy=%b busy=%b err=%b want all 0", tag, S_READY, FFT_A, FFT_START, RD_DATA, FRAME_RDY, BUSY, ERR); end
        RESET = 1'b0;
        #1;
        n_cmp++; if (S_READY !== 1'b1 || BUSY !== 1'b0 || ERR !== 1'b0) begin n_bad++; $display("FAIL %s_release: got ready=%b busy=%b err=%b want 1/0/0", tag, S_READY, BUSY, ERR); end
        for (int k = 0; k < 16; k++) begin
            RD_ADDR = 4'(k);
            tick;
            n_cmp++; if (RD_DATA !== 32'd0) begin n_bad++; $display("FAIL %s_clear[%0d]: got %h want 0", tag, k, RD_DATA); end
        end
    endtask

    task automatic test_reset_mid_send;
        fill(400);
        repeat (5) tick;
        RESET = 1'b1;
        #1;
        check_after_reset("rst_send");
        run_frame(500, 0);
        n_cmp++; if (FRAME_RDY !== 1'b1) begin n_bad++; $display("FAIL rst_send_frame: got rdy=%b want 1", FRAME_RDY); end
        RD_ADDR = 4'd5;
        tick;
        tick;
        n_cmp++; if (RD_DATA !== exp_word(0, 5)) begin n_bad++; $display("FAIL rst_send_bin5: got %h want %h", RD_DATA, exp_word(0, 5)); end
    endtask

    task automatic test_reset_mid_capture;
        fill(600);
        repeat (25) tick;
        FFT_DONE = 1'b1;
        tick;
        FFT_DONE = 1'b0;
        for (int k = 0; k < 8; k++) begin
            FFT_Y = y_word(1, k);
            tick;
        end
        FFT_Y = '0;
        RESET = 1'b1;
        #1;
        check_after_reset("rst_cap");
        run_frame(700, 1);
        n_cmp++; if (FRAME_RDY !== 1'b1) begin n_bad++; $display("FAIL rst_cap_frame: got rdy=%b want 1", FRAME_RDY); end
        tick;
        for (int k = 0; k < 4; k++) begin
            RD_ADDR = 4'(k);
            tick;
            n_cmp++; if (RD_DATA !== exp_word(1, k)) begin n_bad++; $display("FAIL rst_cap_bin[%0d]: got %h want %h", k, RD_DATA, exp_word(1, k)); end
        end
    endtask

    initial begin
        test_reset;
        test_send;
        test_capture;
        test_bank_switch;
        test_mag_corners;
        test_timeout;
        test_reset_mid_send;
        test_reset_mid_capture;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
